sram_rd_scheduler: RTL and testbench
====================================

Name: sram_rd_scheduler

Overview:
- Shares the single SRAM read port (port B: enb/addrb/doutb) among the 16 output-port read arbiters.
- Each output port posts a packet read request (start address, length in 64-bit words). The block selects one port round-robin and streams that packet's addresses to the SRAM.
- It returns the read words with sop/eop/vld tagged one-hot to the owning port.
- Sits between the per-port read arbiters and the sram instance, alongside cache_manager.

Parameters:
- NUM_PORTS, 16, number of requesting output ports.
- DATA_WIDTH, 64, SRAM word width.
- ADDR_WIDTH, 17, SRAM address width.
- LEN_WIDTH, 7, packet length field width, in words.
- RD_LATENCY, 2, SRAM port-B read latency in cycles. Legal range is 1..4.

Ports:
- clk  in  1  single clock, shared by all logic
- rst  in  1  synchronous active-high reset
- req  in  NUM_PORTS  per-port read request; held high until the matching ack
- req_addr  in  NUM_PORTS*ADDR_WIDTH  start address; port i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_len  in  NUM_PORTS*LEN_WIDTH  packet length in words; port i uses bits [i*LEN_WIDTH +: LEN_WIDTH]
- out_ready  in  NUM_PORTS  the destination port can accept words
- ack  out  NUM_PORTS  one-hot, one-cycle pulse when a request is accepted
- enb  out  1  SRAM port-B read enable
- addrb  out  ADDR_WIDTH  SRAM port-B address
- doutb  in  DATA_WIDTH  SRAM port-B read data
- out_vld  out  NUM_PORTS  one-hot: a word is valid for port i
- out_sop  out  NUM_PORTS  one-hot: first word of the packet
- out_eop  out  NUM_PORTS  one-hot: last word of the packet
- out_data  out  DATA_WIDTH  read word, shared by all ports
- busy  out  1  high while in BURST or while words are still in the return pipeline

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE, rr_ptr=0, count=0.
  - Return pipeline cleared.
  - All outputs are 0 from the next cycle.
  - A reset during a BURST aborts the burst. In-flight words are discarded; no eop is emitted.
- FSM states: IDLE and BURST.
- IDLE:
  - If any req bit is set, grant g = first set bit scanning rr_ptr, rr_ptr+1, … mod NUM_PORTS.
  - Same cycle: ack[g]=1 (combinational from state and req).
  - Latch base=req_addr[g], len=req_len[g], gnt=g. Set rr_ptr <= (g+1) mod NUM_PORTS.
  - If len≠0, go to BURST. If len=0, the request is acked and dropped: no reads, stay in IDLE.
- BURST:
  - enb = out_ready[gnt]; addrb = base+count, truncated to ADDR_WIDTH, so it wraps 2^ADDR_WIDTH-1 -> 0.
  - count increments only when enb=1.
  - When enb=1 and count=len-1, return to IDLE next cycle and set count <= 0.
  - out_ready[gnt]=0 stalls issuing: enb=0, addrb held.
- enb and addrb are 0 in IDLE.
- Arbitration gap: exactly one IDLE cycle between consecutive bursts.
- Return pipeline:
  - A tag {vld, sop=(count==0), eop=(count==len-1), port=gnt} enters the pipeline each cycle enb=1.
  - The tag is delayed RD_LATENCY cycles to align with doutb, then registered with doutb into out_*.
  - So a word addressed in cycle t appears on out_* in cycle t+RD_LATENCY+1.
  - out_data holds its last value when no out_vld bit is set. All out_vld/out_sop/out_eop bits are 0 when no word is valid.
- Latency: ack in cycle A, first addrb in A+1, first out_vld in A+2+RD_LATENCY.
- Stall semantics: after out_ready drops, up to RD_LATENCY+1 already-issued words are still delivered. The destination must absorb them.
- Request hold rules:
  - req_addr and req_len are sampled only in the ack cycle.
  - Dropping req before ack withdraws the request; no grant is made.
  - req[gnt] held high during BURST is ignored until the next IDLE.
- A single-word packet (len=1) asserts out_sop and out_eop in the same cycle.
- busy = (state==BURST) | (any pipeline vld).

Test Plan:
- Reset, then req[3]=1, addr=0x00100, len=4, out_ready all 1 -> ack[3] in cycle A. addrb = 0x00100..0x00103 in A+1..A+4. out_vld[3] in A+4..A+7 (RD_LATENCY=2), sop at A+4, eop at A+7, data equals SRAM contents.
- req[0], req[5], req[15] all set, each len=2, held -> grant order 0, 5, 15, then 0 again if re-requested. Each burst is separated by exactly one IDLE cycle.
- req[7], addr=0x1FFFE, len=4 -> addrb sequence 0x1FFFE, 0x1FFFF, 0x00000, 0x00001.
- len=1 on port 2 -> a single word with out_sop[2]=out_eop[2]=out_vld[2]=1. Port len=0 -> ack pulse only, enb never asserted, busy stays 0.
- out_ready[4] dropped for 3 cycles mid-burst (len=8) -> enb low for those cycles, addresses resume without skip or repeat, 8 words delivered in order with one eop.
- rst asserted at the 3rd issued word of a len=10 burst -> all outputs 0 the next cycle, no further out_vld. The next request from port 0 is granted first.

Source files
------------

// File: rtl/sram_rd_scheduler.sv
// Round-robin scheduler sharing SRAM read port B among NUM_PORTS packet readers.
// Streams one packet's addresses per grant and returns words tagged one-hot to the owner.
module sram_rd_scheduler #(
    parameter int unsigned NUM_PORTS  = 16,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 17,
    parameter int unsigned LEN_WIDTH  = 7,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            req,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_PORTS*LEN_WIDTH-1:0]  req_len,
    input  logic [NUM_PORTS-1:0]            out_ready,
    output logic [NUM_PORTS-1:0]            ack,
    output logic                            enb,
    output logic [ADDR_WIDTH-1:0]           addrb,
    input  logic [DATA_WIDTH-1:0]           doutb,
    output logic [NUM_PORTS-1:0]            out_vld,
    output logic [NUM_PORTS-1:0]            out_sop,
    output logic [NUM_PORTS-1:0]            out_eop,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic                            busy
);

    localparam int unsigned PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    state_e                  state_q, state_d;
    logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]        gnt_q, gnt_d;
    logic [LEN_WIDTH-1:0]    count_q, count_d;
    logic [LEN_WIDTH-1:0]    len_q, len_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;

    logic                    grant_found;
    logic [PTR_W-1:0]        grant_idx;
    logic                    issue;
    logic                    last_word;

    logic [ADDR_WIDTH-1:0]   addr_arr [NUM_PORTS];
    logic [LEN_WIDTH-1:0]    len_arr  [NUM_PORTS];

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
        assign addr_arr[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign len_arr[i]  = req_len[i*LEN_WIDTH +: LEN_WIDTH];
    end

    // First requester at or after rr_ptr, wrapping around.
    always_comb begin : rr_search
        int unsigned     idx;
        logic [PTR_W-1:0] cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        cand        = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            idx  = (32'(rr_ptr_q) + k) % NUM_PORTS;
            cand = PTR_W'(idx);
            if (!grant_found && req[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign last_word = (count_q == len_q - LEN_WIDTH'(1));

    always_ff @(posedge clk) begin : fsm_state
        if (rst) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            gnt_q    <= '0;
            count_q  <= '0;
            len_q    <= '0;
            base_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= gnt_d;
            count_q  <= count_d;
            len_q    <= len_d;
            base_q   <= base_d;
        end
    end

    always_comb begin : fsm_next
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gnt_d    = gnt_q;
        count_d  = count_q;
        len_d    = len_q;
        base_d   = base_q;
        unique case (state_q)
            StIdle: begin
                if (grant_found) begin
                    base_d   = addr_arr[grant_idx];
                    len_d    = len_arr[grant_idx];
                    gnt_d    = grant_idx;
                    count_d  = '0;
                    rr_ptr_d = (32'(grant_idx) == NUM_PORTS - 1) ? '0 : grant_idx + PTR_W'(1);
                    // Zero-length requests are acknowledged and dropped.
                    if (len_arr[grant_idx] != '0) state_d = StBurst;
                end
            end
            StBurst: begin
                if (issue) begin
                    if (last_word) begin
                        count_d = '0;
                        state_d = StIdle;
                    end else begin
                        count_d = count_q + LEN_WIDTH'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin : fsm_out
        ack   = '0;
        enb   = 1'b0;
        addrb = '0;
        unique case (state_q)
            StIdle: begin
                if (grant_found && !rst) ack[grant_idx] = 1'b1;
            end
            StBurst: begin
                enb   = out_ready[gnt_q];
                addrb = base_q + ADDR_WIDTH'(count_q);
            end
            default: ;
        endcase
    end

    assign issue = enb;

    // Tag pipeline aligns sop/eop/port with the SRAM read latency.
    logic [RD_LATENCY-1:0] pipe_vld_q, pipe_sop_q, pipe_eop_q;
    logic [PTR_W-1:0]      pipe_port_q [RD_LATENCY];

    always_ff @(posedge clk) begin : tag_pipe
        if (rst) begin
            pipe_vld_q <= '0;
            pipe_sop_q <= '0;
            pipe_eop_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) pipe_port_q[i] <= '0;
        end else begin
            pipe_vld_q[0]  <= issue;
            pipe_sop_q[0]  <= issue && (count_q == '0);
            pipe_eop_q[0]  <= issue && last_word;
            pipe_port_q[0] <= gnt_q;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_vld_q[i]  <= pipe_vld_q[i-1];
                pipe_sop_q[i]  <= pipe_sop_q[i-1];
                pipe_eop_q[i]  <= pipe_eop_q[i-1];
                pipe_port_q[i] <= pipe_port_q[i-1];
            end
        end
    end

    logic [NUM_PORTS-1:0]  out_vld_q, out_sop_q, out_eop_q;
    logic [DATA_WIDTH-1:0] out_data_q;

    always_ff @(posedge clk) begin : out_stage
        if (rst) begin
            out_vld_q  <= '0;
            out_sop_q  <= '0;
            out_eop_q  <= '0;
            out_data_q <= '0;
        end else begin
            out_vld_q <= '0;
            out_sop_q <= '0;
            out_eop_q <= '0;
            if (pipe_vld_q[RD_LATENCY-1]) begin
                out_vld_q[pipe_port_q[RD_LATENCY-1]] <= 1'b1;
                out_sop_q[pipe_port_q[RD_LATENCY-1]] <= pipe_sop_q[RD_LATENCY-1];
                out_eop_q[pipe_port_q[RD_LATENCY-1]] <= pipe_eop_q[RD_LATENCY-1];
                out_data_q                           <= doutb;
            end
        end
    end

    assign out_vld  = out_vld_q;
    assign out_sop  = out_sop_q;
    assign out_eop  = out_eop_q;
    assign out_data = out_data_q;
    assign busy     = (state_q == StBurst) || (|pipe_vld_q);

endmodule

// File: tb/tb_sram_rd_scheduler.sv
// Bench for sram_rd_scheduler: SRAM latency model, address/word scoreboards,
// a table of single-port packets and hand sequences for arbitration, stall and reset.
module tb_sram_rd_scheduler;

    localparam int NP = 16;
    localparam int DW = 64;
    localparam int AW = 17;
    localparam int LW = 7;
    localparam int RL = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP-1:0]     req;
    logic [NP*AW-1:0]  req_addr;
    logic [NP*LW-1:0]  req_len;
    logic [NP-1:0]     out_ready;
    logic [NP-1:0]     ack;
    logic              enb;
    logic [AW-1:0]     addrb;
    logic [DW-1:0]     doutb;
    logic [NP-1:0]     out_vld, out_sop, out_eop;
    logic [DW-1:0]     out_data;
    logic              busy;

    sram_rd_scheduler #(
        .NUM_PORTS (NP),
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .LEN_WIDTH (LW),
        .RD_LATENCY(RL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_addr (req_addr),
        .req_len  (req_len),
        .out_ready(out_ready),
        .ack      (ack),
        .enb      (enb),
        .addrb    (addrb),
        .doutb    (doutb),
        .out_vld  (out_vld),
        .out_sop  (out_sop),
        .out_eop  (out_eop),
        .out_data (out_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {a[15:0], 15'h2A5B, a, ~a[15:0]};
    endfunction

    // SRAM port B: data for the address presented in cycle t is on doutb in cycle t+RL.
    logic [DW-1:0] dpipe [RL];
    always @(posedge clk) begin
        dpipe[0] <= mem_word(addrb);
        for (int i = 1; i < RL; i++) dpipe[i] <= dpipe[i-1];
    end
    assign doutb = dpipe[RL-1];

    typedef struct {
        int          port;
        logic        sop;
        logic        eop;
        logic [DW-1:0] data;
    } exp_t;

    typedef struct {
        int          port;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        logic        exp_busy;
    } vec_t;

    exp_t          exp_q[$];
    logic [AW-1:0] addr_q[$];

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int first_enb_cyc, sop_cyc, eop_cyc;
    int ord[3];

    logic [NP-1:0] ack_s, vld_s, sop_s, eop_s;
    logic          enb_s, busy_s;
    logic [AW-1:0] addrb_s;
    logic [DW-1:0] data_s;

    function automatic logic [NP-1:0] onehot(input int p);
        logic [NP-1:0] v;
        v = 1;
        return v << p;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push_pkt(input int p, input logic [AW-1:0] a, input logic [LW-1:0] n);
        logic [AW-1:0] ad;
        for (int i = 0; i < int'(n); i++) begin
            ad = a + AW'(i);
            addr_q.push_back(ad);
            exp_q.push_back('{p, i == 0, i == int'(n) - 1, mem_word(ad)});
        end
    endtask

    // One clock cycle: sample and score at negedge, return just after the next posedge.
    task automatic step();
        exp_t e;
        @(negedge clk);
        cyc++;
        ack_s = ack; enb_s = enb; addrb_s = addrb; busy_s = busy;
        vld_s = out_vld; sop_s = out_sop; eop_s = out_eop; data_s = out_data;
        if (!rst) begin
            if (enb) begin
                if (first_enb_cyc < 0) first_enb_cyc = cyc;
                if (addr_q.size() == 0) chk("unexpected_enb", 64'(addrb), 64'h1_FFFF_FFFF);
                else chk("addrb", 64'(addrb), 64'(addr_q.pop_front()));
            end
            if (out_vld != '0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_vld", 64'(out_vld), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_vld", 64'(out_vld), 64'(onehot(e.port)));
                    chk("out_sop", 64'(out_sop), e.sop ? 64'(onehot(e.port)) : 64'd0);
                    chk("out_eop", 64'(out_eop), e.eop ? 64'(onehot(e.port)) : 64'd0);
                    chk("out_data", out_data, e.data);
                    if (e.sop) sop_cyc = cyc;
                    if (e.eop) eop_cyc = cyc;
                end
            end else begin
                chk("stray_tag", 64'({out_sop, out_eop}), 64'd0);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic request(input int p, input logic [AW-1:0] a, input logic [LW-1:0] n,
                           output int acyc);
        req_addr[p*AW +: AW] = a;
        req_len[p*LW +: LW]  = n;
        req[p]               = 1'b1;
        acyc                 = -1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (ack_s != '0) begin
                acyc = cyc;
                break;
            end
        end
        chk("ack", 64'(ack_s), 64'(onehot(p)));
        req[p] = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || addr_q.size() != 0) && t < 200) begin
            step();
            t++;
        end
        chk("drain", 64'(exp_q.size() + addr_q.size()), 64'd0);
        repeat (2) step();
    endtask

    // Ports in ord[0..n-1] request together; grants must follow ord, len+1 cycles apart.
    task automatic arb_run(input int n, input logic [LW-1:0] len);
        int k, last;
        logic [AW-1:0] a;
        k    = 0;
        last = -1;
        for (int i = 0; i < n; i++) begin
            a = AW'(32'h300 + ord[i] * 16);
            req_addr[ord[i]*AW +: AW] = a;
            req_len[ord[i]*LW +: LW]  = len;
            push_pkt(ord[i], a, len);
        end
        for (int i = 0; i < n; i++) req[ord[i]] = 1'b1;
        for (int t = 0; t < 60 && k < n; t++) begin
            step();
            if (ack_s != '0) begin
                chk("arb_order", 64'(ack_s), 64'(onehot(ord[k])));
                if (last >= 0) chk("arb_gap", 64'(cyc - last), 64'(int'(len) + 1));
                last = cyc;
                req  = req & ~ack_s;
                k++;
            end
        end
        chk("arb_count", 64'(k), 64'(n));
        req = '0;
        drain();
    endtask

    vec_t vecs[5];
    int   acyc;

    initial begin
        vecs[0] = '{7,  17'h1FFFE, 7'd4, 1'b1};
        vecs[1] = '{2,  17'h00040, 7'd1, 1'b1};
        vecs[2] = '{9,  17'h00200, 7'd0, 1'b0};
        vecs[3] = '{12, 17'h01234, 7'd3, 1'b1};
        vecs[4] = '{15, 17'h0ABCD, 7'd5, 1'b1};

        first_enb_cyc = -1;
        sop_cyc       = -1;
        eop_cyc       = -1;
        rst       = 1'b1;
        req       = '0;
        req_addr  = '0;
        req_len   = '0;
        out_ready = '1;
        repeat (2) step();
        rst = 1'b0;
        step();
        chk("rst_ack", 64'(ack_s), 64'd0);
        chk("rst_enb", 64'(enb_s), 64'd0);
        chk("rst_addrb", 64'(addrb_s), 64'd0);
        chk("rst_vld", 64'(vld_s), 64'd0);
        chk("rst_busy", 64'(busy_s), 64'd0);
        chk("rst_data", data_s, 64'd0);

        // Basic 4-word packet: latency of address and data.
        push_pkt(3, 17'h00100, 7'd4);
        first_enb_cyc = -1;
        request(3, 17'h00100, 7'd4, acyc);
        drain();
        chk("lat_first_addr", 64'(first_enb_cyc), 64'(acyc + 1));
        chk("lat_sop", 64'(sop_cyc), 64'(acyc + 4));
        chk("lat_eop", 64'(eop_cyc), 64'(acyc + 7));

        // Table: address wrap, single word, zero length, ordinary packets.
        for (int v = 0; v < 5; v++) begin
            push_pkt(vecs[v].port, vecs[v].addr, vecs[v].len);
            first_enb_cyc = -1;
            request(vecs[v].port, vecs[v].addr, vecs[v].len, acyc);
            step();
            chk("vec_busy", 64'(busy_s), 64'(vecs[v].exp_busy));
            if (vecs[v].len == '0) begin
                repeat (4) begin
                    step();
                    chk("len0_busy", 64'(busy_s), 64'd0);
                end
                chk("len0_no_enb", 64'(first_enb_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
            end
            drain();
        end

        // Round-robin among 0, 5, 15 starting from pointer 0, then 0 again before 5.
        ord[0] = 0; ord[1] = 5; ord[2] = 15;
        arb_run(3, 7'd2);
        ord[0] = 0; ord[1] = 5;
        arb_run(2, 7'd2);

        // Stall port 4 for three cycles mid-burst.
        push_pkt(4, 17'h00800, 7'd8);
        request(4, 17'h00800, 7'd8, acyc);
        repeat (2) step();
        out_ready[4] = 1'b0;
        repeat (3) begin
            step();
            chk("stall_enb", 64'(enb_s), 64'd0);
            chk("stall_addrb", 64'(addrb_s), 64'h802);
        end
        out_ready = '1;
        drain();

        // Reset on the third issued word of a 10-word burst.
        push_pkt(6, 17'h00900, 7'd10);
        request(6, 17'h00900, 7'd10, acyc);
        repeat (2) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        addr_q.delete();
        step();
        chk("abort_ack", 64'(ack_s), 64'd0);
        chk("abort_enb", 64'(enb_s), 64'd0);
        chk("abort_addrb", 64'(addrb_s), 64'd0);
        chk("abort_vld", 64'({vld_s, sop_s, eop_s}), 64'd0);
        chk("abort_busy", 64'(busy_s), 64'd0);
        chk("abort_data", data_s, 64'd0);
        repeat (8) step();
        ord[0] = 0; ord[1] = 8;
        arb_run(2, 7'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
